inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
// Fetch stage upstream of the MIPS datapath: fetches 32-bit words from a variable-latency
// instruction store via a req/ack handshake, buffers them with their PC in a prefetch FIFO,
// and presents opc/inst to the decode/datapath with valid/ready. Branch, jump and jr targets
// arrive on redirect and flush all prefetched work.
// PARAMETERS
// DEPTH    4             prefetch FIFO entries; power of two, >= 2
// RESET_PC 32'h00000000  first fetch address after reset
// PORTS
// clk          in   1   clock, all state on rising edge
// rst          in   1   asynchronous, active-low reset
// redirect     in   1   1-cycle pulse: flush and restart fetch at redirect_pc
// redirect_pc  in   32  new fetch address; bits [1:0] forced to 0
// mem_req      out  1   fetch request, held until accepted
// mem_addr     out  32  byte address of requested word, stable while mem_req=1
// mem_ack      in   1   request accepted; mem_rdata valid this cycle
// mem_rdata    in   32  fetched word, big-endian, [31:26]=opcode
// inst_valid   out  1   FIFO head valid
// inst_ready   in   1   consumer takes head when inst_valid & inst_ready
// opc          out  6   head word [31:26]
// inst         out  26  head word [25:0]
// inst_pc      out  32  address of head word
// pc_plus4     out  32  inst_pc + 4, modulo 2^32
// BEHAVIOUR
// - Reset: fetch_pc=RESET_PC, FIFO empty, state FETCH; inst_valid=0, opc/inst/inst_pc/pc_plus4=0.
//   First mem_req=1 in the first cycle after rst rises.
// - Transfer = mem_req & mem_ack. One outstanding request max; no new request before transfer.
// - FSM, 2 states:
//   FETCH:   mem_req = (count < DEPTH); mem_addr = fetch_pc. On transfer: push {fetch_pc,
//            mem_rdata}, fetch_pc += 4 (0xFFFFFFFC wraps to 0).
//   DISCARD: mem_req=1, mem_addr = held address of the in-flight request; on transfer data
//            dropped, -> FETCH.
// - Since count only falls while a request waits, mem_req never drops before ack.
// - Redirect (highest priority, any state): FIFO cleared same edge, fetch_pc <= redirect_pc&~3.
//   If mem_req=1 and mem_ack=0 that cycle -> DISCARD (old addr held until ack).
//   If mem_ack=1 that cycle -> data dropped, stay/go FETCH.
//   If mem_req=0 -> FETCH.
//   Redirect during DISCARD: fetch_pc updated, remain DISCARD.
//   A pop coinciding with redirect counts as consumed; nothing else is delivered pre-flush.
// - Latency: transfer at edge t -> inst_valid=1 from cycle t+1 (registered, no bypass).
//   Redirect at t -> earliest mem_req to new pc at t+1 (FETCH case).
// - Full: count==DEPTH -> mem_req=0. Push+pop same cycle: count unchanged, order kept.
// - Empty: inst_valid=0; opc/inst/inst_pc/pc_plus4 driven 0.
// - inst_ready ignored when inst_valid=0; head outputs stable until popped or flushed.
// - rst assertion mid-transaction: all state to reset values immediately; a pending
//   ack from the store is not expected after reset.
// STRUCTURE
// - Shared include (mips_defs.vh): FETCH/DISCARD state codes, INST_W=32, OPC_W=6, PC_INC=4.
// - One sub-module: fetch_fifo (sync FIFO, WIDTH=64 {pc,word}, DEPTH, push/pop/flush,
//   count, empty/full; flush overrides push and pop). FSM, pc and handshake in the top.
// TESTING
// - Reset, store acks every cycle, consumer always ready -> mem_addr 0,4,8,...;
//   inst_pc 0,4,8 in order, pc_plus4 = inst_pc+4, first inst_valid 2 cycles after rst rises.
// - inst_ready=0 -> exactly DEPTH(4) transfers then mem_req=0; ready=1 one cycle -> one pop,
//   mem_req reasserts next cycle at addr 0x10.
// - Store acks after 3 cycles, redirect to 0x100 in cycle 1 of wait -> mem_addr held at old
//   value until ack, that word never appears, next request 0x100, head inst_pc=0x100.
// - Redirect coincident with ack -> word dropped, FIFO empty next cycle, mem_addr=0x100.
// - redirect_pc=0xFFFFFFFE -> fetch at 0xFFFFFFFC, then 0x00000000; pc_plus4 of it = 0.
// - rst low mid-wait with FIFO holding 3 entries -> inst_valid=0, outputs 0 immediately;
//   after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state codes, word and
// field widths, the FIFO entry layout and small PC helper functions.
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

  // Fetch FSM states: FETCH issues sequential requests, DISCARD waits out a
  // request that was made stale by a redirect.
  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } fetch_state_e;

  localparam int          INST_W  = 32;
  localparam int          OPC_W   = 6;
  localparam int          PC_W    = 32;
  localparam int          ENTRY_W = PC_W + INST_W;
  localparam logic [31:0] PC_INC  = 32'd4;

  // One prefetch FIFO entry: the word and the address it was fetched from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] word;
  } fetch_entry_t;

  // Sequential successor; wraps naturally modulo 2^32.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

  // Force word alignment of an externally supplied target address.
  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding prefetched {pc, word} entries.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, wdata     write an entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; overrides push and pop in the same cycle
//   rdata           head entry, all zeros when empty
//   count           number of stored entries (0..DEPTH)
//   empty, full     occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == DEPTH_C);
  assign count     = count_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Head presentation; zeroed when empty so consumers never see stale data.
  always_comb begin
    rdata = {WIDTH{1'b0}};
    if (!empty) begin
      rdata = mem_r[rd_ptr_r];
    end else begin
      rdata = {WIDTH{1'b0}};
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; only written on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Fetch stage: requests 32-bit words from a variable-latency instruction store
// over a req/ack handshake, buffers {pc, word} in a prefetch FIFO and presents
// the head to decode with valid/ready. A redirect flushes prefetched work and
// restarts fetch at the new target.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   redirect, redirect_pc    one-cycle restart request and target (bits [1:0] ignored)
//   mem_req, mem_addr        fetch request and its byte address
//   mem_ack, mem_rdata       request accepted and the returned word
//   inst_valid, inst_ready   head handshake toward decode
//   opc, inst                head word split into opcode [31:26] and remainder
//   inst_pc, pc_plus4        head address and its sequential successor
// -----------------------------------------------------------------------------
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [OPC_W-1:0]  opc,
  output logic [25:0]       inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [PC_W-1:0] fetch_pc_r;
  logic [PC_W-1:0] fetch_pc_nxt_s;
  logic [PC_W-1:0] hold_addr_r;
  logic [PC_W-1:0] hold_addr_nxt_s;

  logic            req_s;
  logic [PC_W-1:0] addr_s;
  logic            xfer_s;
  logic            push_s;
  logic            pop_s;
  fetch_entry_t    wentry_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   fifo_count_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;

  // Request side: sequential fetch throttled by free FIFO space, or the
  // stale in-flight address that must stay on the bus until acknowledged.
  always_comb begin
    req_s  = 1'b0;
    addr_s = fetch_pc_r;
    case (state_r)
      ST_FETCH: begin
        req_s  = (fifo_count_s < DEPTH_C);
        addr_s = fetch_pc_r;
      end
      ST_DISCARD: begin
        req_s  = 1'b1;
        addr_s = hold_addr_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = fetch_pc_r;
      end
    endcase
  end

  assign xfer_s = req_s & mem_ack;

  // Next-state, next-pc and push decision; redirect takes priority over
  // everything, and a word landing in the redirect cycle is dropped.
  always_comb begin
    state_nxt_s     = state_r;
    fetch_pc_nxt_s  = fetch_pc_r;
    hold_addr_nxt_s = hold_addr_r;
    push_s          = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (redirect) begin
          fetch_pc_nxt_s = pc_align(redirect_pc);
          if (req_s && !mem_ack) begin
            state_nxt_s     = ST_DISCARD;
            hold_addr_nxt_s = fetch_pc_r;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else if (xfer_s) begin
          push_s         = ~fifo_full_s;
          fetch_pc_nxt_s = pc_next(fetch_pc_r);
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          fetch_pc_nxt_s = pc_align(redirect_pc);
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        // The stale word is thrown away; fetch resumes at fetch_pc next cycle.
        if (mem_ack) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
  end

  // FSM and address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_FETCH;
      fetch_pc_r  <= pc_align(RESET_PC);
      hold_addr_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      fetch_pc_r  <= fetch_pc_nxt_s;
      hold_addr_r <= hold_addr_nxt_s;
    end
  end

  assign wentry_s.pc   = fetch_pc_r;
  assign wentry_s.word = mem_rdata;
  assign pop_s         = ~fifo_empty_s & inst_ready;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect),
    .wdata (wentry_s),
    .rdata (head_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign mem_req    = req_s;
  assign mem_addr   = addr_s;
  assign inst_valid = ~fifo_empty_s;
  assign opc        = head_s.word[31:26];
  assign inst       = head_s.word[25:0];
  assign inst_pc    = head_s.pc;

  // Successor of the head address; zero while nothing is presented.
  always_comb begin
    pc_plus4 = 32'h0000_0000;
    if (!fifo_empty_s) begin
      pc_plus4 = pc_next(head_s.pc);
    end else begin
      pc_plus4 = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed stimulus with a scoreboard: each test pushes the {pc} sequence it
// expects decode to receive; a monitor pops and compares on every handshake.
// A small instruction-store model acks after a programmable latency and a
// programmable number of times.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [5:0]  opc;
  logic [25:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;

  int checks = 0;
  int passes = 0;
  int mem_lat = 0;
  int acks_left = 0;
  int wait_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .opc(opc), .inst(inst),
    .inst_pc(inst_pc), .pc_plus4(pc_plus4)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:2], a[27:2]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction store: acks after mem_lat waiting cycles while acks remain.
  always @(posedge clk) begin
    #1;
    if (!rst || acks_left == 0) begin
      mem_ack = 1'b0; wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack = 1'b1; mem_rdata = word_of(mem_addr); acks_left--; wait_cnt = 0;
      end else begin
        mem_ack = 1'b0; wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0; wait_cnt = 0;
    end
  end

  // Monitor: every decode handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] w;
    if (rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pop: got inst_pc %h, expected no delivery", inst_pc);
      end else begin
        e = exp_q.pop_front();
        w = word_of(e);
        check("pop_inst_pc", inst_pc, e);
        check("pop_word", {opc, inst}, w);
        check("pop_pc_plus4", pc_plus4, e + 32'd4);
      end
    end
  end

  task automatic hold_reset();
    acks_left = 0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_head", {opc, inst}, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || inst_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_bounded", {31'd0, n < 300}, 32'd1);
    check("drain_queue", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    // T1: streaming, store acks every cycle, consumer always ready.
    hold_reset();
    mem_lat = 0; acks_left = 8; inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    release_reset();
    #1;
    check("t1_first_req", {31'd0, mem_req}, 32'd1);
    check("t1_first_addr", mem_addr, 32'h0);
    @(negedge clk);
    check("t1_valid_cycle1", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_cycle2", {31'd0, inst_valid}, 32'd1);
    drain();

    // T2: consumer stalled -> exactly four transfers, one pop frees one slot.
    hold_reset();
    mem_lat = 0; acks_left = 5;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    release_reset();
    repeat (8) @(negedge clk);
    check("t2_full_req", {31'd0, mem_req}, 32'd0);
    check("t2_full_xfers", acks_left, 32'd1);
    check("t2_head_pc", inst_pc, 32'h0);
    @(posedge clk); #1 inst_ready = 1'b1;
    @(posedge clk); #1 inst_ready = 1'b0;
    @(negedge clk);
    check("t2_rereq", {31'd0, mem_req}, 32'd1);
    check("t2_rereq_addr", mem_addr, 32'h10);
    @(posedge clk); #1 inst_ready = 1'b1;
    drain();

    // T3: redirect while a slow request is waiting -> stale word discarded.
    hold_reset();
    mem_lat = 3; acks_left = 2; inst_ready = 1'b1;
    exp_q.push_back(32'h100);
    release_reset();
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t3_hold_req", {31'd0, mem_req}, 32'd1);
    check("t3_hold_addr", mem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t3_ack_seen", {31'd0, mem_ack}, 32'd1);
    check("t3_ack_addr", mem_addr, 32'h0);
    @(negedge clk);
    check("t3_new_addr", mem_addr, 32'h100);
    check("t3_no_stale", {31'd0, inst_valid}, 32'd0);
    drain();

    // T4: redirect coincident with ack -> word dropped and FIFO flushed.
    hold_reset();
    mem_lat = 0; acks_left = 5;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t4_prefill", {31'd0, inst_valid}, 32'd1);
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t4_flushed", {31'd0, inst_valid}, 32'd0);
    check("t4_new_addr", mem_addr, 32'h100);
    inst_ready = 1'b1;
    drain();

    // T5: unaligned target near the top of memory; address wraps to zero.
    hold_reset();
    mem_lat = 0; acks_left = 3; inst_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    release_reset();
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t5_aligned_addr", mem_addr, 32'hFFFF_FFFC);
    check("t5_dropped", {31'd0, inst_valid}, 32'd0);
    drain();

    // T6: reset asserted mid-wait with three entries buffered.
    hold_reset();
    mem_lat = 0; acks_left = 3;
    release_reset();
    repeat (5) @(negedge clk);
    check("t6_valid", {31'd0, inst_valid}, 32'd1);
    check("t6_head", inst_pc, 32'h0);
    check("t6_wait_addr", mem_addr, 32'hC);
    check("t6_wait_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_async_head", {opc, inst}, 32'd0);
    check("t6_async_pc", inst_pc, 32'd0);
    check("t6_async_plus4", pc_plus4, 32'd0);
    acks_left = 2; inst_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    release_reset();
    #1;
    check("t6_restart_addr", mem_addr, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
